step_input: RTL and testbench

Lane-tracking stage directly downstream of the PS/2 `keyboard` decoder. Consumes decoded scan-code events (`keyCode`/`press` plus a one-cycle valid strobe) and maps the four arrow scan codes to game lanes. Tracks per-lane held state and suppresses typematic repeats. Time-stamps each genuine press/release edge and queues the events in a small FIFO for the judging logic, using a valid/ready handshake.

---
 rtl/step_pkg.sv | 14 +
 rtl/step_event_fifo.sv | 41 ++++
 rtl/step_input.sv | 86 ++++++++
 tb/tb_step_input.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// step_pkg: shared lane enum, event payload and default scan codes for step_input
package step_pkg;
  typedef enum logic [1:0] {LEFT = 2'd0, DOWN = 2'd1, UP = 2'd2, RIGHT = 2'd3} lane_t;
  localparam int TS_W_DEF = 16;
  localparam logic [7:0] CODE_LEFT_DEF = 8'h6B;
  localparam logic [7:0] CODE_DOWN_DEF = 8'h72;
  localparam logic [7:0] CODE_UP_DEF = 8'h75;
  localparam logic [7:0] CODE_RIGHT_DEF = 8'h74;
  typedef struct packed {
    lane_t lane;
    logic press;
    logic [TS_W_DEF-1:0] ts;
  } step_event_t;
endpackage

// File: rtl/step_event_fifo.sv
// step_event_fifo: first-word-fall-through event queue with wrap-bit pointers
module step_event_fifo
  import step_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = step_event_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic wr_en, rd_en;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    rd_en = pop && !empty;
    // a pop frees the slot, so a push into a full queue is still taken
    wr_en = push && (!full || rd_en);
    wr_d = wr_q + (AW+1)'(wr_en);
    rd_d = rd_q + (AW+1)'(rd_en);
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/step_input.sv
// step_input: arrow-key lane tracker with repeat suppression and timestamped event queue
module step_input
  import step_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = 8,
  parameter logic [7:0] CODE_LEFT = CODE_LEFT_DEF,
  parameter logic [7:0] CODE_DOWN = CODE_DOWN_DEF,
  parameter logic [7:0] CODE_UP = CODE_UP_DEF,
  parameter logic [7:0] CODE_RIGHT = CODE_RIGHT_DEF
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic [7:0]      key_code,
  input  logic            key_press,
  input  logic            key_valid,
  output logic [3:0]      lane_held,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [1:0]      ev_lane,
  output logic            ev_press,
  output logic [TS_W-1:0] ev_time,
  output logic [TS_W-1:0] time_now,
  output logic            overflow,
  input  logic            clear_ovf
);
  localparam int PW = $clog2(TICK_DIV);
  typedef struct packed {
    lane_t lane;
    logic press;
    logic [TS_W-1:0] ts;
  } ev_t;
  logic [PW-1:0] pre_q, pre_d;
  logic [TS_W-1:0] time_q, time_d;
  logic [3:0] held_q, held_d;
  logic ovf_q, ovf_d;
  logic hit, push, pop, full, empty;
  lane_t lane;
  ev_t din, dout;
  always_comb begin
    pre_d = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + 1'b1;
    time_d = time_q + TS_W'(pre_q == PW'(TICK_DIV - 1));
    lane = (key_code == CODE_LEFT) ? LEFT : (key_code == CODE_DOWN) ? DOWN :
           (key_code == CODE_UP) ? UP : RIGHT;
    hit = key_code inside {CODE_LEFT, CODE_DOWN, CODE_UP, CODE_RIGHT};
    // only a change of held state is an edge; repeats and stray breaks fall out here
    push = key_valid && hit && (key_press != held_q[lane]);
    held_d = held_q;
    if (push) held_d[lane] = key_press;
    din = '{lane: lane, press: key_press, ts: time_q};
    pop = !empty && ev_ready;
    ovf_d = (push && full && !pop) || (ovf_q && !clear_ovf);
  end
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      pre_q <= '0;
      time_q <= '0;
      held_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      time_q <= time_d;
      held_q <= held_d;
      ovf_q <= ovf_d;
    end
  step_event_fifo #(.DEPTH(DEPTH), .T(ev_t)) u_fifo (
    .clk(Clk),
    .rst_n(reset_n),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    lane_held = held_q;
    ev_valid = !empty;
    ev_lane = empty ? 2'd0 : dout.lane;
    ev_press = !empty && dout.press;
    ev_time = empty ? '0 : dout.ts;
    time_now = time_q;
    overflow = ovf_q;
  end
endmodule

// File: tb/tb_step_input.sv
// tb_step_input: directed and random stimulus against a queue-based model of step_input
module tb_step_input;
  localparam int TD = 4, TW = 16, DP = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] key_code = '0;
  logic key_press = 1'b0, key_valid = 1'b0, ev_ready = 1'b0, clear_ovf = 1'b0;
  logic [3:0] lane_held;
  logic ev_valid, ev_press, overflow;
  logic [1:0] ev_lane;
  logic [TW-1:0] ev_time, time_now;
  typedef struct {int lane; bit press; int ts;} ev_s;
  ev_s q[$];
  bit m_held[4];
  bit m_ovf;
  int cyc, total, bad;
  always #5 clk = ~clk;
  step_input #(.TICK_DIV(TD), .TS_W(TW), .DEPTH(DP)) dut (
    .Clk(clk), .reset_n(reset_n), .key_code(key_code), .key_press(key_press),
    .key_valid(key_valid), .lane_held(lane_held), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_lane(ev_lane), .ev_press(ev_press), .ev_time(ev_time), .time_now(time_now),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );
  function automatic int lane_of(logic [7:0] c);
    case (c)
      8'h6B: return 0;
      8'h72: return 1;
      8'h75: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("lane_held", 32'(lane_held), {28'd0, m_held[3], m_held[2], m_held[1], m_held[0]});
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("ev_lane", 32'(ev_lane), 32'(q[0].lane));
      chk("ev_press", 32'(ev_press), 32'(q[0].press));
      chk("ev_time", 32'(ev_time), 32'(q[0].ts));
    end
    chk("time_now", 32'(time_now), (cyc / TD) % 65536);
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask
  task automatic cyc1(input logic [7:0] c, input bit p, input bit v, input bit r, input bit clr);
    int l, ts;
    bit pop, push, drop;
    key_code = c; key_press = p; key_valid = v; ev_ready = r; clear_ovf = clr;
    l = lane_of(c);
    ts = (cyc / TD) % 65536;
    pop = q.size() > 0 && r;
    push = 0;
    if (v && l >= 0) push = (p != m_held[l]);
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    drop = push && q.size() == DP;
    if (push) begin
      m_held[l] = p;
      if (!drop) q.push_back('{l, p, ts});
    end
    m_ovf = drop || (m_ovf && !clr);
    #1;
    key_valid = 1'b0; clear_ovf = 1'b0;
    check_all();
  endtask
  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc1(8'h00, 1'b0, 1'b0, r, 1'b0);
  endtask
  task automatic model_reset();
    q.delete();
    m_held = '{default: 0};
    m_ovf = 0;
    cyc = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_held"}, 32'(lane_held), 0);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_lane"}, 32'(ev_lane), 0);
    chk({tag, "_press"}, 32'(ev_press), 0);
    chk({tag, "_evtime"}, 32'(ev_time), 0);
    chk({tag, "_now"}, 32'(time_now), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask
  initial begin
    logic [7:0] codes [6];
    codes = '{8'h6B, 8'h72, 8'h75, 8'h74, 8'h1C, 8'h00};
    model_reset();
    #2 chk_zero("rst0");
    #10 reset_n = 1'b1;
    idle(13, 0);
    chk("ts_13edges", 32'(time_now), 3);
    cyc1(8'h74, 1, 1, 0, 0);
    chk("ts_ev_time", 32'(ev_time), 3);
    chk("ts_ev_valid", 32'(ev_valid), 1);
    cyc1(8'h74, 0, 1, 0, 0);
    idle(3, 1);
    cyc1(8'h6B, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc1(8'h6B, 1, 1, 0, 0);
    chk("rep_held", 32'(lane_held), 32'b0001);
    cyc1(8'h6B, 0, 1, 0, 0);
    chk("rep_head_lane", 32'(ev_lane), 0);
    chk("rep_head_press", 32'(ev_press), 1);
    cyc1(8'h00, 0, 0, 1, 0);
    chk("rep_second_press", 32'(ev_press), 0);
    cyc1(8'h00, 0, 0, 1, 0);
    chk("rep_empty", 32'(ev_valid), 0);
    cyc1(8'h1C, 1, 1, 0, 0);
    cyc1(8'h72, 0, 1, 0, 0);
    chk("filt_valid", 32'(ev_valid), 0);
    chk("filt_held", 32'(lane_held), 0);
    for (int i = 0; i < 10; i++) cyc1(codes[i % 4], i < 4 || i >= 8, 1, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    cyc1(8'h00, 0, 0, 0, 1);
    chk("ovf_clear", 32'(overflow), 0);
    cyc1(8'h6B, 0, 1, 1, 0);
    chk("full_popush_ovf", 32'(overflow), 0);
    cyc1(8'h72, 0, 1, 0, 0);
    chk("still_full_ovf", 32'(overflow), 1);
    cyc1(8'h00, 0, 0, 1, 1);
    idle(10, 1);
    cyc1(8'h75, 1, 1, 0, 0);
    cyc1(8'h74, 1, 1, 0, 0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_zero("rst_mid");
    model_reset();
    #2 reset_n = 1'b1;
    idle(2, 1);
    for (int i = 0; i < 400; i++)
      cyc1(codes[$urandom_range(0, 5)], 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    idle(12, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
